// File: rtl/rst_sequencer.sv
// Staged reset sequencer: holds every downstream stage in reset, then releases
// the stages one by one, and restarts the sequence on a fault or a software request.
module rst_sequencer #(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned HOLD_CYC   = 8,
  parameter int unsigned STAGE_DLY  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_rst_req,
  input  logic                  fault,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  sys_rdy,
  output logic                  sw_rst_ack,
  output logic [7:0]            restart_cnt
);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RELEASE,
    ST_RUN
  } state_t;

  localparam logic [7:0]            HOLD_LAST = 8'(HOLD_CYC - 1);
  localparam logic [7:0]            DLY_LAST  = 8'(STAGE_DLY - 1);
  localparam logic [2:0]            IDX_LAST  = 3'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] STAGE_ONE = NUM_STAGES'(1);

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [2:0]              idx_q, idx_d;
  logic [NUM_STAGES-1:0]   stage_q, stage_d;
  logic                    rdy_q, rdy_d;
  logic                    ack_q, ack_d;
  logic [7:0]              rcnt_q, rcnt_d;
  logic                    restart;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      rdy_q   <= 1'b0;
      ack_q   <= 1'b0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      rdy_q   <= rdy_d;
      ack_q   <= ack_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    rdy_d   = rdy_q;
    ack_d   = 1'b0;
    rcnt_d  = rcnt_q;
    restart = 1'b0;

    unique case (state_q)
      ST_HOLD: begin
        stage_d = '0;
        rdy_d   = 1'b0;
        // A fault here only stretches the hold; it is not counted as a restart.
        if (fault) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_RELEASE: begin
        if (fault) begin
          restart = 1'b1;
        end else if (cnt_q == DLY_LAST) begin
          stage_d = stage_q | (STAGE_ONE << idx_q);
          cnt_d   = '0;
          idx_d   = idx_q + 3'd1;
          if (idx_q == IDX_LAST) begin
            state_d = ST_RUN;
            rdy_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_RUN: begin
        stage_d = '1;
        rdy_d   = 1'b1;
        if (fault || sw_rst_req) begin
          restart = 1'b1;
          ack_d   = sw_rst_req;
        end
      end

      default: state_d = ST_HOLD;
    endcase

    // Shared restart path for RELEASE and RUN aborts.
    if (restart) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      stage_d = '0;
      rdy_d   = 1'b0;
      if (rcnt_q != 8'hFF) rcnt_d = rcnt_q + 8'd1;
    end
  end

  assign stage_rst_n = stage_q;
  assign sys_rdy     = rdy_q;
  assign sw_rst_ack  = ack_q;
  assign restart_cnt = rcnt_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: a timeline model predicts outputs per edge,
// a monitor compares them on the falling edge; directed scenarios pin key edges.
module tb_rst_sequencer;

  localparam int unsigned NS = 3;
  localparam int unsigned H  = 8;
  localparam int unsigned D  = 16;

  logic          clk;
  logic          rst;
  logic          sw_rst_req;
  logic          fault;
  logic [NS-1:0] stage_rst_n;
  logic          sys_rdy;
  logic          sw_rst_ack;
  logic [7:0]    restart_cnt;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  bit          req_on   = 0;

  rst_sequencer #(
    .NUM_STAGES(NS),
    .HOLD_CYC  (H),
    .STAGE_DLY (D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_rst_req (sw_rst_req),
    .fault      (fault),
    .stage_rst_n(stage_rst_n),
    .sys_rdy    (sys_rdy),
    .sw_rst_ack (sw_rst_ack),
    .restart_cnt(restart_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: n = edges since the sequence origin (rst release or restart edge).
  typedef struct packed {
    logic [NS-1:0] stg;
    logic          rdy;
    logic          ack;
    logic [7:0]    rc;
  } exp_t;

  exp_t        sb[$];
  exp_t        me;
  exp_t        mon_e;
  int unsigned n_m  = 0;
  int unsigned rc_m = 0;
  int unsigned rel_m;
  bit          ack_m;

  always @(posedge clk) begin
    ack_m = 1'b0;
    if (rst) begin
      n_m  = 0;
      rc_m = 0;
    end else if (n_m < H) begin
      n_m = fault ? 0 : n_m + 1;
    end else if (fault || (n_m >= H + NS * D && sw_rst_req)) begin
      ack_m = (n_m >= H + NS * D) && sw_rst_req;
      n_m   = 0;
      rc_m  = (rc_m >= 255) ? 255 : rc_m + 1;
    end else if (n_m < H + NS * D) begin
      n_m = n_m + 1;
    end
    if (n_m < H) rel_m = 0;
    else rel_m = ((n_m - H) / D > NS) ? NS : (n_m - H) / D;
    me.stg = NS'((1 << rel_m) - 1);
    me.rdy = (rel_m == NS);
    me.ack = ack_m;
    me.rc  = 8'(rc_m);
    sb.push_back(me);
  end

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("sb_stage", 32'(stage_rst_n), 32'(mon_e.stg));
      chk("sb_rdy", 32'(sys_rdy), 32'(mon_e.rdy));
      chk("sb_ack", 32'(sw_rst_ack), 32'(mon_e.ack));
      chk("sb_rcnt", 32'(restart_cnt), 32'(mon_e.rc));
    end
  end

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Asserts rst between edges, checks outputs settle immediately, releases at a negedge.
  task automatic async_rst();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_stage", 32'(stage_rst_n), 32'd0);
    chk("async_rdy", 32'(sys_rdy), 32'd0);
    chk("async_ack", 32'(sw_rst_ack), 32'd0);
    chk("async_rcnt", 32'(restart_cnt), 32'd0);
    fault      = 1'b0;
    sw_rst_req = 1'b0;
    req_on     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_rdy(input int unsigned limit);
    int unsigned k = 0;
    while (!sys_rdy && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("rdy_timeout", 32'(sys_rdy), 32'd1);
  endtask

  initial begin
    int unsigned e;
    logic [7:0]  rc0;
    rst        = 1'b0;
    fault      = 1'b0;
    sw_rst_req = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("por_stage", 32'(stage_rst_n), 32'd0);
    chk("por_rdy", 32'(sys_rdy), 32'd0);
    chk("por_rcnt", 32'(restart_cnt), 32'd0);
    cycles(3);
    rst = 1'b0;

    // Default release timeline
    cycles(23); chk("e23_stage", 32'(stage_rst_n), 32'b000);
    cycles(1);  chk("e24_stage", 32'(stage_rst_n), 32'b001);
    cycles(15); chk("e39_stage", 32'(stage_rst_n), 32'b001);
    cycles(1);  chk("e40_stage", 32'(stage_rst_n), 32'b011);
    cycles(15); chk("e55_rdy", 32'(sys_rdy), 32'd0);
    cycles(1);  chk("e56_stage", 32'(stage_rst_n), 32'b111);
    chk("e56_rdy", 32'(sys_rdy), 32'd1);
    chk("e56_rcnt", 32'(restart_cnt), 32'd0);

    // One-clock software request in RUN
    cycles(3);
    sw_rst_req = 1'b1;
    cycles(1);
    sw_rst_req = 1'b0;
    chk("sw_ack", 32'(sw_rst_ack), 32'd1);
    chk("sw_stage", 32'(stage_rst_n), 32'd0);
    chk("sw_rcnt", 32'(restart_cnt), 32'd1);
    cycles(1);  chk("sw_ack_drop", 32'(sw_rst_ack), 32'd0);
    cycles(54); chk("sw_r55_rdy", 32'(sys_rdy), 32'd0);
    cycles(1);  chk("sw_r56_rdy", 32'(sys_rdy), 32'd1);

    // Fault during RELEASE at edge 30
    async_rst();
    cycles(29);
    fault = 1'b1;
    cycles(1);
    fault = 1'b0;
    chk("f30_stage", 32'(stage_rst_n), 32'd0);
    chk("f30_rcnt", 32'(restart_cnt), 32'd1);
    cycles(23); chk("f53_stage", 32'(stage_rst_n), 32'b000);
    cycles(1);  chk("f54_stage", 32'(stage_rst_n), 32'b001);

    // Persistent fault in HOLD from edge 3 for 100 clocks
    async_rst();
    cycles(2);
    fault = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cycles(1);
      chk("pf_stage", 32'(stage_rst_n), 32'd0);
    end
    fault = 1'b0;
    chk("pf_rcnt", 32'(restart_cnt), 32'd0);
    cycles(23); chk("pf_e125_stage", 32'(stage_rst_n), 32'b000);
    cycles(1);  chk("pf_e126_stage", 32'(stage_rst_n), 32'b001);

    // Fault and request together in RUN
    wait_rdy(200);
    cycles(2);
    rc0        = restart_cnt;
    fault      = 1'b1;
    sw_rst_req = 1'b1;
    cycles(1);
    fault      = 1'b0;
    sw_rst_req = 1'b0;
    chk("both_ack", 32'(sw_rst_ack), 32'd1);
    chk("both_rcnt", 32'(restart_cnt), 32'(rc0) + 32'd1);
    cycles(1); chk("both_ack_drop", 32'(sw_rst_ack), 32'd0);

    // Request held from edge 10 is acked on the first RUN clock
    async_rst();
    cycles(9);
    sw_rst_req = 1'b1;
    e = 9;
    while (!sw_rst_ack && e < 200) begin
      cycles(1);
      e++;
    end
    sw_rst_req = 1'b0;
    chk("held_ack_edge", e, 32'd57);

    // Randomized traffic with a handshaking requester and rare async resets
    wait_rdy(200);
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if (req_on) begin
        if (sw_rst_ack) begin
          sw_rst_req = 1'b0;
          req_on     = 1'b0;
        end
      end else if ($urandom_range(0, 99) < 3) begin
        sw_rst_req = 1'b1;
        req_on     = 1'b1;
      end
      fault = ($urandom_range(0, 99) < 1);
      if ($urandom_range(0, 599) == 0) async_rst();
    end
    fault      = 1'b0;
    sw_rst_req = 1'b0;
    req_on     = 1'b0;

    // Counter saturation: 300 faults, each landing in RELEASE
    async_rst();
    for (int i = 0; i < 300; i++) begin
      cycles(H + 1);
      fault = 1'b1;
      cycles(1);
      fault = 1'b0;
    end
    chk("sat_rcnt", 32'(restart_cnt), 32'd255);
    cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3, meaning the number of staged reset outputs (legal range 1..8).
REQ-002 SHALL have parameter HOLD_CYC, default 8, meaning the clocks all stages are held in reset before release begins (legal range 1..255).
REQ-003 SHALL have parameter STAGE_DLY, default 16, meaning the clocks between consecutive stage releases (legal range 1..255).
REQ-004 SHALL have port clk, input, 1 bit: the system clock; all state changes on posedge clk.
REQ-005 SHALL have port rst, input, 1 bit: one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port sw_rst_req, input, 1 bit: software reset request, level; the requester holds it high until sw_rst_ack.
REQ-007 SHALL have port fault, input, 1 bit: fault indication, level, synchronous to clk.
REQ-008 SHALL have port stage_rst_n, output, NUM_STAGES bits: active-low reset per downstream stage; bit 0 is released first.
REQ-009 SHALL have port sys_rdy, output, 1 bit: high only when all stages are released.
REQ-010 SHALL have port sw_rst_ack, output, 1 bit: one-clock pulse accepting a software reset.
REQ-011 SHALL have port restart_cnt, output, 8 bits: saturating count of sequence restarts since rst.

Function
REQ-012 SHALL implement the registered states HOLD, RELEASE and RUN, with one delay counter and one stage index.
REQ-013 HOLD SHALL drive all stage_rst_n bits to 0 and sys_rdy to 0, and SHALL increment the counter each clock.
REQ-014 HOLD SHALL move to RELEASE, with the counter and stage index cleared, on the edge where the counter equals HOLD_CYC-1, so HOLD lasts exactly HOLD_CYC clocks.
REQ-015 RELEASE SHALL increment the counter each clock; on the edge where the counter equals STAGE_DLY-1 it SHALL set stage_rst_n[index] to 1, increment the index and clear the counter.
REQ-016 Stage k SHALL therefore be released at edge HOLD_CYC+(k+1)*STAGE_DLY, counted from the first edge after rst deasserts.
REQ-017 Stages SHALL release strictly in ascending order, and a released stage SHALL stay released until the next restart.
REQ-018 On the edge that releases stage NUM_STAGES-1, the block SHALL enter RUN and set sys_rdy to 1 on that same edge.
REQ-019 RUN SHALL hold all stage_rst_n bits at 1 and sys_rdy at 1 while sw_rst_req and fault are both low.
REQ-020 In RUN, sw_rst_req high at an edge SHALL cause, on that edge: state to HOLD, counter to 0, all stage_rst_n to 0, sys_rdy to 0, sw_rst_ack to 1 for exactly one clock, and restart_cnt to increment.
REQ-021 In RUN, fault high at an edge SHALL cause the same transition as REQ-020, without asserting sw_rst_ack.
REQ-022 Simultaneous fault and sw_rst_req in RUN SHALL assert sw_rst_ack once and increment restart_cnt once.
REQ-023 In RELEASE, fault high SHALL reassert all stage_rst_n to 0, enter HOLD with the counter at 0, and increment restart_cnt.
REQ-024 In HOLD, fault high SHALL clear the counter, extending HOLD, without incrementing restart_cnt; a persistent fault therefore keeps the block in HOLD.
REQ-025 In HOLD or RELEASE, sw_rst_req SHALL be ignored with no ack; a request held high SHALL be acked on the first RUN clock.
REQ-026 restart_cnt SHALL saturate at 255 and SHALL NOT wrap.
REQ-027 stage_rst_n, sys_rdy and sw_rst_ack SHALL be driven directly from flops, with no combinational path from any input.

Reset
REQ-028 rst high SHALL immediately, without waiting for a clock edge, force: state HOLD, counter 0, index 0, stage_rst_n all 0, sys_rdy 0, sw_rst_ack 0, restart_cnt 0.
REQ-029 rst asserted mid-sequence or in RUN SHALL abort the sequence, and release SHALL restart per REQ-014 after rst deasserts.

Verification
REQ-030 Defaults, rst deasserted before edge 1 -> stage_rst_n goes 000->001 at edge 24, 011 at edge 40, 111 at edge 56; sys_rdy 1 at edge 56; restart_cnt 0.
REQ-031 In RUN, 1-clock sw_rst_req pulse -> same edge: sw_rst_ack=1 for 1 clock, stage_rst_n=000, restart_cnt=1; full release again after 56 clocks.
REQ-032 fault pulse at edge 30 (stage 0 released) -> stage_rst_n=000 at edge 30, restart_cnt=1, stage 0 re-released at edge 54.
REQ-033 fault held high for 100 clocks from edge 3 -> stage_rst_n stays 000 throughout, restart_cnt stays 0; stage 0 releases 24 clocks after fault drops.
REQ-034 sw_rst_req and fault high together in RUN -> exactly one ack pulse, restart_cnt +1; sw_rst_req held from edge 10 -> ack at edge 57 only.
REQ-035 rst asserted between edges mid-RELEASE -> outputs reach reset values before the next edge; 300 forced restarts -> restart_cnt=255.
